router_sync_nch: RTL and testbench

//  Parametrised N-channel router synchronizer between the FSM/register front end and the output FIFOs.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_sync_timer.sv | 59 +++++
 rtl/router_sync_nch.sv | 90 +++++++++
 tb/tb_router_sync_nch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router synchronizer slice.
//   NUM_CH_DEF/ADDR_W_DEF/TIMEOUT_DEF/CNT_W_DEF : default parameter values
//   MAX_CH / MAX_ADDR_W                          : widest supported decode
//   onehot(addr, n) : MAX_CH-bit one-hot of addr, all-zero when addr >= n
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;
  localparam int CNT_W_DEF   = 5;
  localparam int MAX_CH      = 8;
  localparam int MAX_ADDR_W  = 8;

  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr,
                                              input int unsigned           n);
    logic [MAX_CH-1:0] r;
    r = '0;
    // n never exceeds MAX_CH, so a passing compare keeps addr within 3 bits
    if ({24'd0, addr} < n[31:0]) r[addr[2:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel read-timeout timer.
//   clock, reset : rising-edge clock, async active-high reset
//   vld          : channel FIFO holds data
//   rd           : downstream is reading the channel this cycle
//   en           : timeout counting enabled for the channel
//   clr          : clear the sticky status flag
//   soft_reset   : one-cycle flush pulse after TIMEOUT unread-valid cycles
//   stat         : sticky timeout flag
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  input  logic en,
  input  logic clr,
  output logic soft_reset,
  output logic stat
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_stat;
  logic             w_cond;
  logic             w_hit;

  assign w_cond = vld & ~rd & en;
  assign w_hit  = w_cond && (r_cnt == LAST);

  // Counter restarts on any broken cycle and after each pulse, so it never
  // passes LAST and the pulse cannot repeat on consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (!w_cond || w_hit) begin
      r_cnt   <= '0;
      r_pulse <= w_hit;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_pulse <= 1'b0;
    end
  end

  // Set wins over clear so a timeout coinciding with a clear is not lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_stat <= 1'b0;
    else if (w_hit) r_stat <= 1'b1;
    else if (clr)   r_stat <= 1'b0;
  end

  assign soft_reset = r_pulse;
  assign stat       = r_stat;

endmodule

// File: rtl/router_sync_nch.sv
// N-channel router synchronizer between the FSM front end and output FIFOs.
//   clock, reset   : rising-edge clock, async active-high reset
//   detect_add     : capture data_in as destination address
//   data_in        : header address field
//   write_enb_reg  : FSM write request
//   write_enb      : one-hot FIFO write enable (zero on bad address)
//   fifo_full      : full flag of addressed FIFO (zero on bad address)
//   addr_err       : latched address is not a valid channel
//   full, empty    : per-FIFO status
//   read_enb       : per-channel downstream read
//   vld_out        : per-channel data valid (~empty)
//   timeout_en     : per-channel timeout enable
//   soft_reset     : per-channel one-cycle flush pulse
//   timeout_stat   : per-channel sticky timeout flag
//   stat_clr       : per-channel status clear
module router_sync_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] vld_out,
  input  logic [NUM_CH-1:0] timeout_en,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] timeout_stat,
  input  logic [NUM_CH-1:0] stat_clr
);

  logic [ADDR_W-1:0]     r_addr;
  logic                  r_addr_err;
  logic [MAX_ADDR_W-1:0] w_addr_ext;
  logic [MAX_CH-1:0]     w_sel;
  logic [MAX_CH-1:0]     w_full_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      r_addr     <= data_in;
      r_addr_err <= (32'(data_in) >= 32'(NUM_CH));
    end
  end

  always_comb begin
    w_addr_ext             = '0;
    w_addr_ext[ADDR_W-1:0] = r_addr;
    w_full_ext             = '0;
    w_full_ext[NUM_CH-1:0] = full;
  end

  // Decode is already zero for out-of-range addresses; the addr_err gate
  // keeps the outputs quiet off the latched flag as well.
  assign w_sel     = onehot(w_addr_ext, NUM_CH);
  assign fifo_full = !r_addr_err && |(w_full_ext & w_sel);
  assign addr_err  = r_addr_err;
  assign vld_out   = ~empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign write_enb[i] = write_enb_reg && !r_addr_err && w_sel[i];

    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_tmr (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .en         (timeout_en[i]),
      .clr        (stat_clr[i]),
      .soft_reset (soft_reset[i]),
      .stat       (timeout_stat[i])
    );
  end

endmodule

// File: tb/tb_router_sync_nch.sv
module tb_router_sync_nch;

  localparam int NCH = 3;
  localparam int AW  = 2;
  localparam int TO  = 30;
  localparam int CW  = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           detect_add;
  logic [AW-1:0]  data_in;
  logic           write_enb_reg;
  logic [NCH-1:0] write_enb;
  logic           fifo_full;
  logic           addr_err;
  logic [NCH-1:0] full, empty, read_enb, vld_out, timeout_en, soft_reset, timeout_stat, stat_clr;

  router_sync_nch #(.NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .write_enb(write_enb), .fifo_full(fifo_full),
    .addr_err(addr_err), .full(full), .empty(empty), .read_enb(read_enb),
    .vld_out(vld_out), .timeout_en(timeout_en), .soft_reset(soft_reset),
    .timeout_stat(timeout_stat), .stat_clr(stat_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NCH-1:0] we;
    logic           ff;
    logic           err;
    logic [NCH-1:0] vld;
    logic [NCH-1:0] sr;
    logic [NCH-1:0] st;
  } exp_t;

  exp_t q[$];
  event drv_ev;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: destination register plus, per channel, the length of
  // the current run of unread-valid enabled cycles.
  int             m_addr;
  bit             m_err;
  int             m_run[NCH];
  bit [NCH-1:0]   m_sr, m_st;
  int             pulses = 0;
  int             multi_pulses = 0;
  int             err_seen = 0;

  task automatic model_clear();
    m_addr = 0; m_err = 0; m_sr = '0; m_st = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
  endtask

  task automatic cyc(input bit rst, input bit det, input int din, input bit wer,
                     input logic [NCH-1:0] fl, em, rd, en, clr);
    exp_t e;
    @(negedge clock);
    reset = rst; detect_add = det; data_in = AW'(din); write_enb_reg = wer;
    full = fl; empty = em; read_enb = rd; timeout_en = en; stat_clr = clr;
    if (rst) model_clear();
    e.we  = (wer && !m_err) ? NCH'(1 << m_addr) : '0;
    e.ff  = !m_err ? fl[m_addr] : 1'b0;
    e.err = m_err;
    e.vld = ~em;
    e.sr  = m_sr;
    e.st  = m_st;
    q.push_back(e);
    -> drv_ev;
    @(posedge clock);
    if (!rst) begin
      if (det) begin
        m_addr = din; m_err = (din >= NCH);
        if (m_err) err_seen++;
      end
      for (int c = 0; c < NCH; c++) begin
        m_sr[c] = 1'b0;
        if (!em[c] && !rd[c] && en[c]) begin
          m_run[c]++;
          if (m_run[c] == TO) begin
            m_sr[c] = 1'b1; m_run[c] = 0; pulses++;
          end
        end else m_run[c] = 0;
        if (m_sr[c]) m_st[c] = 1'b1;
        else if (clr[c]) m_st[c] = 1'b0;
      end
      if ($countones(m_sr) > 1) multi_pulses++;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(drv_ev);
      #1;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("write_enb",    8'(write_enb),    8'(e.we));
        chk("fifo_full",    8'(fifo_full),    8'(e.ff));
        chk("addr_err",     8'(addr_err),     8'(e.err));
        chk("vld_out",      8'(vld_out),      8'(e.vld));
        chk("soft_reset",   8'(soft_reset),   8'(e.sr));
        chk("timeout_stat", 8'(timeout_stat), 8'(e.st));
      end
    end
  end

  initial begin
    model_clear();
    reset = 1'b1; detect_add = 0; data_in = '0; write_enb_reg = 0;
    full = '0; empty = '1; read_enb = '0; timeout_en = '0; stat_clr = '0;
    // reset state
    repeat (3) cyc(1, 0, 0, 0, '0, '1, '0, '0, '0);
    // address capture / decode, valid and invalid destination
    cyc(0, 1, 2, 1, 3'b100, '1, '0, '0, '0);
    cyc(0, 0, 0, 1, 3'b100, '1, '0, '0, '0);
    cyc(0, 0, 0, 1, 3'b011, '1, '0, '0, '0);
    cyc(0, 1, 3, 1, 3'b111, '1, '0, '0, '0);
    cyc(0, 0, 0, 1, 3'b111, '1, '0, '0, '0);
    cyc(0, 1, 0, 1, 3'b001, '1, '0, '0, '0);
    cyc(0, 0, 0, 1, 3'b001, '1, '0, '0, '0);
    // channel 0 timeout, then status clear
    repeat (33) cyc(0, 0, 0, 0, '0, 3'b110, '0, 3'b001, '0);
    cyc(0, 0, 0, 0, '0, '1, '0, 3'b001, 3'b001);
    cyc(0, 0, 0, 0, '0, '1, '0, 3'b001, '0);
    // read at cycle 29 defers the timeout a full period
    repeat (28) cyc(0, 0, 0, 0, '0, 3'b110, '0, 3'b001, '0);
    cyc(0, 0, 0, 0, '0, 3'b110, 3'b001, 3'b001, '0);
    repeat (32) cyc(0, 0, 0, 0, '0, 3'b110, '0, 3'b001, '0);
    // simultaneous timeouts on channels 1 and 2, then channel 1 disabled
    cyc(1, 0, 0, 0, '0, '1, '0, '0, '0);
    repeat (32) cyc(0, 0, 0, 0, '0, 3'b001, '0, 3'b110, '0);
    cyc(1, 0, 0, 0, '0, '1, '0, '0, '0);
    repeat (32) cyc(0, 0, 0, 0, '0, 3'b001, '0, 3'b100, '0);
    // reset mid-count; afterwards a full period is needed again
    repeat (15) cyc(0, 1, 1, 1, '1, 3'b000, '0, 3'b111, '0);
    cyc(1, 0, 0, 1, '1, 3'b000, '0, 3'b111, '0);
    repeat (32) cyc(0, 0, 0, 1, '1, 3'b000, '0, 3'b111, '0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] em, rd, en, clr;
      for (int c = 0; c < NCH; c++) begin
        em[c]  = ($urandom_range(0, 39) == 0);
        rd[c]  = ($urandom_range(0, 49) == 0);
        en[c]  = ($urandom_range(0, 19) != 0);
        clr[c] = ($urandom_range(0, 15) == 0);
      end
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 3)), 1'($urandom), NCH'($urandom), em, rd, en, clr);
    end
    @(negedge clock);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    vectors++;
    if (pulses == 0 || multi_pulses == 0 || err_seen == 0) begin
      miscompares++;
      $display("FAIL coverage: got pulses=%0d multi=%0d err=%0d expected all nonzero",
               pulses, multi_pulses, err_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
